// File: rtl/mem_access.sv
// MEM pipeline stage: req/ack bus loads/stores with lane alignment, sign
// extension, pipeline hold while the bus is busy, and an access timeout.
module mem_access #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk_100MHz,
    input  logic        arst_n,
    input  logic [31:0] inst_i,
    input  logic        reg_w_ena_i,
    input  logic [4:0]  reg_w_addr_i,
    input  logic [31:0] reg_w_data_i,
    input  logic        mem_r_ena_i,
    input  logic        mem_w_ena_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_w_data_i,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o,
    output logic [31:0] bus_wdata_o,
    output logic [3:0]  bus_wstrb_o,
    input  logic        bus_ack_i,
    input  logic [31:0] bus_rdata_i,
    output logic        hold_req_o,
    output logic        err_o,
    output logic [31:0] inst_o,
    output logic        reg_w_ena_o,
    output logic [4:0]  reg_w_addr_o,
    output logic [31:0] reg_w_data_o,
    output logic        mem_r_ena_o,
    output logic        mem_w_ena_o,
    output logic [31:0] mem_r_addr_o,
    output logic [31:0] mem_w_addr_o,
    output logic [31:0] mem_r_data_o,
    output logic [31:0] mem_w_data_o
);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t      state, state_nxt;
    logic [7:0]  cnt, cnt_nxt;
    logic [31:0] cap, cap_nxt;
    logic        tout, tout_nxt;

    logic [2:0]  funct3;
    logic [1:0]  lane;
    logic        mem_req;
    logic        misaligned;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_val;
    logic [3:0]  strb;

    assign funct3  = inst_i[14:12];
    assign lane    = mem_addr_i[1:0];
    assign mem_req = mem_r_ena_i | mem_w_ena_i;

    // Size decode: funct3[1:0] = 00 byte, 01 half, otherwise word.
    always_comb begin
        misaligned  = 1'b0;
        strb        = 4'b1111;
        bus_wdata_o = mem_w_data_i;
        case (funct3[1:0])
            2'b00: begin
                strb        = 4'b0001 << lane;
                bus_wdata_o = {4{mem_w_data_i[7:0]}};
            end
            2'b01: begin
                misaligned  = mem_addr_i[0];
                strb        = mem_addr_i[1] ? 4'b1100 : 4'b0011;
                bus_wdata_o = {2{mem_w_data_i[15:0]}};
            end
            default: misaligned = |mem_addr_i[1:0];
        endcase
    end

    always_comb begin
        ld_byte = bus_rdata_i[7:0];
        case (lane)
            2'd1:    ld_byte = bus_rdata_i[15:8];
            2'd2:    ld_byte = bus_rdata_i[23:16];
            2'd3:    ld_byte = bus_rdata_i[31:24];
            default: ld_byte = bus_rdata_i[7:0];
        endcase
        ld_half = mem_addr_i[1] ? bus_rdata_i[31:16] : bus_rdata_i[15:0];
        case (funct3[1:0])
            2'b00:   ld_val = {{24{ld_byte[7] & ~funct3[2]}}, ld_byte};
            2'b01:   ld_val = {{16{ld_half[15] & ~funct3[2]}}, ld_half};
            default: ld_val = bus_rdata_i;
        endcase
    end

    always_ff @(posedge clk_100MHz or negedge arst_n) begin
        if (!arst_n) begin
            state <= IDLE;
            cnt   <= '0;
            cap   <= '0;
            tout  <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            cap   <= cap_nxt;
            tout  <= tout_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        cap_nxt      = cap;
        tout_nxt     = tout;
        hold_req_o   = 1'b0;
        bus_req_o    = 1'b0;
        err_o        = 1'b0;
        reg_w_ena_o  = reg_w_ena_i;
        reg_w_data_o = reg_w_data_i;
        case (state)
            IDLE: begin
                if (mem_req) begin
                    if (misaligned) begin
                        err_o       = 1'b1;
                        reg_w_ena_o = 1'b0;
                    end else begin
                        hold_req_o = 1'b1;
                        state_nxt  = ACCESS;
                        cnt_nxt    = '0;
                        tout_nxt   = 1'b0;
                    end
                end
            end
            ACCESS: begin
                bus_req_o  = 1'b1;
                hold_req_o = 1'b1;
                if (bus_ack_i) begin
                    cap_nxt   = ld_val;
                    state_nxt = DONE;
                end else begin
                    cnt_nxt = cnt + 8'd1;
                    // cnt is compared before increment, so the abort lands on wait cycle TIMEOUT_CYCLES
                    if (cnt == CNT_LAST) begin
                        err_o     = 1'b1;
                        cap_nxt   = '0;
                        tout_nxt  = 1'b1;
                        state_nxt = DONE;
                    end
                end
            end
            DONE: begin
                state_nxt = IDLE;
                if (tout)
                    reg_w_ena_o = 1'b0;
                if (mem_r_ena_i)
                    reg_w_data_o = cap;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus_we_o     = (state == ACCESS) & mem_w_ena_i;
    assign bus_wstrb_o  = ((state == ACCESS) & mem_w_ena_i) ? strb : 4'b0000;
    assign bus_addr_o   = {mem_addr_i[31:2], 2'b00};

    assign inst_o       = inst_i;
    assign reg_w_addr_o = reg_w_addr_i;
    assign mem_r_ena_o  = mem_r_ena_i;
    assign mem_w_ena_o  = mem_w_ena_i;
    assign mem_r_addr_o = mem_addr_i;
    assign mem_w_addr_o = mem_addr_i;
    assign mem_w_data_o = mem_w_data_i;
    assign mem_r_data_o = cap;

endmodule

// File: tb/tb_mem_access.sv
// Bench for mem_access: directed scenarios then randomized transactions,
// checked against an arithmetic reference model of the bus/alignment rules.
module tb_mem_access;

    localparam int unsigned TMO = 4;

    logic        clk_100MHz = 1'b0;
    logic        arst_n;
    logic [31:0] inst_i;
    logic        reg_w_ena_i;
    logic [4:0]  reg_w_addr_i;
    logic [31:0] reg_w_data_i;
    logic        mem_r_ena_i;
    logic        mem_w_ena_i;
    logic [31:0] mem_addr_i;
    logic [31:0] mem_w_data_i;
    logic        bus_req_o;
    logic        bus_we_o;
    logic [31:0] bus_addr_o;
    logic [31:0] bus_wdata_o;
    logic [3:0]  bus_wstrb_o;
    logic        bus_ack_i;
    logic [31:0] bus_rdata_i;
    logic        hold_req_o;
    logic        err_o;
    logic [31:0] inst_o;
    logic        reg_w_ena_o;
    logic [4:0]  reg_w_addr_o;
    logic [31:0] reg_w_data_o;
    logic        mem_r_ena_o;
    logic        mem_w_ena_o;
    logic [31:0] mem_r_addr_o;
    logic [31:0] mem_w_addr_o;
    logic [31:0] mem_r_data_o;
    logic [31:0] mem_w_data_o;

    int tests = 0;
    int fails = 0;

    always #5 clk_100MHz = ~clk_100MHz;

    mem_access #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk_100MHz   (clk_100MHz),
        .arst_n       (arst_n),
        .inst_i       (inst_i),
        .reg_w_ena_i  (reg_w_ena_i),
        .reg_w_addr_i (reg_w_addr_i),
        .reg_w_data_i (reg_w_data_i),
        .mem_r_ena_i  (mem_r_ena_i),
        .mem_w_ena_i  (mem_w_ena_i),
        .mem_addr_i   (mem_addr_i),
        .mem_w_data_i (mem_w_data_i),
        .bus_req_o    (bus_req_o),
        .bus_we_o     (bus_we_o),
        .bus_addr_o   (bus_addr_o),
        .bus_wdata_o  (bus_wdata_o),
        .bus_wstrb_o  (bus_wstrb_o),
        .bus_ack_i    (bus_ack_i),
        .bus_rdata_i  (bus_rdata_i),
        .hold_req_o   (hold_req_o),
        .err_o        (err_o),
        .inst_o       (inst_o),
        .reg_w_ena_o  (reg_w_ena_o),
        .reg_w_addr_o (reg_w_addr_o),
        .reg_w_data_o (reg_w_data_o),
        .mem_r_ena_o  (mem_r_ena_o),
        .mem_w_ena_o  (mem_w_ena_o),
        .mem_r_addr_o (mem_r_addr_o),
        .mem_w_addr_o (mem_w_addr_o),
        .mem_r_data_o (mem_r_data_o),
        .mem_w_data_o (mem_w_data_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr,
                                               input logic [31:0] rdata);
        int unsigned lane;
        longint      v;
        lane = addr % 4;
        if (f3[1:0] == 2'b00) begin
            v = (rdata >> (8 * lane)) & 255;
            if (!f3[2] && v >= 128) v = v - 256;
        end else if (f3[1:0] == 2'b01) begin
            v = (rdata >> (16 * (lane / 2))) & 65535;
            if (!f3[2] && v >= 32768) v = v - 65536;
        end else begin
            v = rdata;
        end
        return 32'(v);
    endfunction

    function automatic int unsigned op_size(input logic [2:0] f3);
        return (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    endfunction

    function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] wd);
        case (op_size(f3))
            1:       return (wd & 32'hFF) * 32'h0101_0101;
            2:       return (wd & 32'hFFFF) * 32'h0001_0001;
            default: return wd;
        endcase
    endfunction

    task automatic drive_op(input logic [2:0] f3, input logic rd, input logic wr,
                            input logic [31:0] addr, input logic [31:0] wd);
        logic [31:0] ins;
        ins = $urandom;
        ins[14:12] = f3;
        inst_i       = ins;
        reg_w_ena_i  = 1'($urandom);
        reg_w_addr_i = 5'($urandom);
        reg_w_data_i = $urandom;
        mem_r_ena_i  = rd;
        mem_w_ena_i  = wr;
        mem_addr_i   = addr;
        mem_w_data_i = wd;
    endtask

    task automatic drive_nop();
        drive_op(3'($urandom), 1'b0, 1'b0, $urandom, $urandom);
    endtask

    task automatic passthru();
        @(posedge clk_100MHz); #1;
        drive_nop();
        bus_ack_i   = 1'($urandom);
        bus_rdata_i = $urandom;
        #1;
        chk("pt_inst", inst_o, inst_i);
        chk("pt_wena", 32'(reg_w_ena_o), 32'(reg_w_ena_i));
        chk("pt_waddr", 32'(reg_w_addr_o), 32'(reg_w_addr_i));
        chk("pt_wdata", reg_w_data_o, reg_w_data_i);
        chk("pt_rena", 32'(mem_r_ena_o), 32'(mem_r_ena_i));
        chk("pt_mwena", 32'(mem_w_ena_o), 32'(mem_w_ena_i));
        chk("pt_raddr", mem_r_addr_o, mem_addr_i);
        chk("pt_maddr", mem_w_addr_o, mem_addr_i);
        chk("pt_mwdata", mem_w_data_o, mem_w_data_i);
        chk("pt_hold", 32'(hold_req_o), 32'd0);
        chk("pt_breq", 32'(bus_req_o), 32'd0);
        chk("pt_err", 32'(err_o), 32'd0);
        bus_ack_i = 1'b0;
    endtask

    // ack_at: ACCESS cycle (1-based) carrying the ack; 0 or > TMO means no ack.
    task automatic mem_op(input logic [2:0] f3, input logic is_load, input logic [31:0] addr,
                          input logic [31:0] wd, input int unsigned ack_at,
                          input logic [31:0] rdata, input logic dir, input logic [31:0] dir_val);
        logic [31:0] exp_data;
        logic        sv_ena;
        logic [31:0] sv_data;
        logic        ack;
        logic        timed;
        int unsigned holds;
        int unsigned k;
        bit          done;
        @(posedge clk_100MHz); #1;
        drive_op(f3, is_load, !is_load, addr, wd);
        bus_ack_i = 1'b0;
        #1;
        sv_ena  = reg_w_ena_i;
        sv_data = reg_w_data_i;
        if ((addr % op_size(f3)) != 0) begin
            chk("mis_err", 32'(err_o), 32'd1);
            chk("mis_hold", 32'(hold_req_o), 32'd0);
            chk("mis_breq", 32'(bus_req_o), 32'd0);
            chk("mis_wena", 32'(reg_w_ena_o), 32'd0);
            @(posedge clk_100MHz); #1;
            drive_nop();
            #1;
            chk("mis_idle_breq", 32'(bus_req_o), 32'd0);
            chk("mis_idle_hold", 32'(hold_req_o), 32'd0);
            return;
        end
        chk("st_err", 32'(err_o), 32'd0);
        chk("st_hold", 32'(hold_req_o), 32'd1);
        chk("st_breq", 32'(bus_req_o), 32'd0);
        holds = 32'(hold_req_o);
        k     = 0;
        done  = 1'b0;
        while (!done) begin
            @(posedge clk_100MHz); #1;
            k++;
            ack         = (k == ack_at);
            bus_ack_i   = ack;
            bus_rdata_i = ack ? rdata : $urandom;
            #1;
            chk("acc_breq", 32'(bus_req_o), 32'd1);
            chk("acc_addr", bus_addr_o, addr & 32'hFFFF_FFFC);
            chk("acc_we", 32'(bus_we_o), 32'(!is_load));
            if (is_load) begin
                chk("acc_strb_rd", 32'(bus_wstrb_o), 32'd0);
            end else begin
                chk("acc_strb", 32'(bus_wstrb_o), ((32'd1 << op_size(f3)) - 1) << (addr % 4));
                chk("acc_wdata", bus_wdata_o, model_wdata(f3, wd));
            end
            chk("acc_err", 32'(err_o), 32'(!ack && k == TMO));
            holds += 32'(hold_req_o);
            if (ack || k >= TMO) done = 1'b1;
        end
        timed = (ack_at == 0) || (ack_at > TMO);
        @(posedge clk_100MHz); #1;
        bus_ack_i = 1'b0;
        #1;
        exp_data = is_load ? (timed ? 32'd0 : model_load(f3, addr, rdata)) : sv_data;
        chk("done_hold", 32'(hold_req_o), 32'd0);
        chk("done_breq", 32'(bus_req_o), 32'd0);
        chk("done_err", 32'(err_o), 32'd0);
        chk("done_wena", 32'(reg_w_ena_o), timed ? 32'd0 : 32'(sv_ena));
        chk("done_wdata", reg_w_data_o, exp_data);
        if (is_load) chk("done_rdata", mem_r_data_o, exp_data);
        if (dir) chk("done_directed", reg_w_data_o, dir_val);
        chk("hold_cycles", 32'(holds), 32'(1 + (timed ? TMO : ack_at)));
        @(posedge clk_100MHz); #1;
        drive_nop();
        #1;
        chk("post_hold", 32'(hold_req_o), 32'd0);
        chk("post_breq", 32'(bus_req_o), 32'd0);
    endtask

    initial begin
        logic [2:0] ld_f3 [5];
        logic [2:0] st_f3 [3];
        logic [2:0] f3;
        ld_f3 = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        st_f3 = '{3'b000, 3'b001, 3'b010};

        arst_n      = 1'b0;
        bus_ack_i   = 1'b0;
        bus_rdata_i = '0;
        drive_nop();
        #12;
        chk("rst_breq", 32'(bus_req_o), 32'd0);
        chk("rst_hold", 32'(hold_req_o), 32'd0);
        chk("rst_err", 32'(err_o), 32'd0);
        chk("rst_cap", mem_r_data_o, 32'd0);
        @(negedge clk_100MHz);
        arst_n = 1'b1;

        passthru();
        mem_op(3'b000, 1'b1, 32'h0000_1003, 32'd0, 3, 32'h80FF_FF12, 1'b1, 32'hFFFF_FF80);
        mem_op(3'b101, 1'b1, 32'h0000_2002, 32'd0, 1, 32'h8001_0000, 1'b1, 32'h0000_8001);
        mem_op(3'b000, 1'b0, 32'h0000_3001, 32'h0000_00AB, 2, 32'd0, 1'b0, 32'd0);
        mem_op(3'b010, 1'b1, 32'h0000_4002, 32'd0, 1, 32'd0, 1'b0, 32'd0);
        mem_op(3'b010, 1'b1, 32'h0000_5000, 32'd0, 0, 32'd0, 1'b1, 32'd0);

        // Reset while the bus request is outstanding, then a stray ack in IDLE.
        @(posedge clk_100MHz); #1;
        drive_op(3'b010, 1'b1, 1'b0, 32'h0000_6000, 32'd0);
        repeat (2) @(posedge clk_100MHz);
        #2;
        chk("mid_breq_before", 32'(bus_req_o), 32'd1);
        arst_n = 1'b0;
        #1;
        chk("mid_breq_reset", 32'(bus_req_o), 32'd0);
        drive_nop();
        @(posedge clk_100MHz); #1;
        arst_n      = 1'b1;
        bus_ack_i   = 1'b1;
        bus_rdata_i = 32'h1234_5678;
        @(posedge clk_100MHz); #1;
        bus_ack_i = 1'b0;
        #1;
        chk("late_ack_hold", 32'(hold_req_o), 32'd0);
        chk("late_ack_breq", 32'(bus_req_o), 32'd0);
        chk("late_ack_cap", mem_r_data_o, 32'd0);

        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 2))
                0: passthru();
                1: begin
                    f3 = ld_f3[$urandom_range(0, 4)];
                    mem_op(f3, 1'b1, $urandom, 32'd0, $urandom_range(0, TMO + 1), $urandom,
                           1'b0, 32'd0);
                end
                default: begin
                    f3 = st_f3[$urandom_range(0, 2)];
                    mem_op(f3, 1'b0, $urandom, $urandom, $urandom_range(0, TMO + 1), $urandom,
                           1'b0, 32'd0);
                end
            endcase
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
